// File: rtl/entity_slot_loader.sv
// Entity slot loader: assembles 3-byte packets into a shadow bank of entity words and
// commits it to the active bank on frame_start. Optional build macro: ENTITY_CLEAR_ALL_EN.
module entity_slot_loader #(
    parameter int unsigned NUM_SLOTS = 9,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                data_in,
    input  logic                      data_valid,
    input  logic                      frame_start,
    output logic [NUM_SLOTS*14-1:0]   entities,
    output logic                      busy,
    output logic                      pkt_err,
    output logic                      commit
);

    localparam logic [13:0] UNUSED_WORD = 14'h3C00;
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [4:0]  SLOT_LIMIT  = 5'(NUM_SLOTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_B0 = 2'd1,
        GOT_B1 = 2'd2
    } state_e;

    state_e                        state_q;
    logic [3:0]                    slot_q;
    logic [3:0]                    id_q;
    logic [1:0]                    orient_q;
    logic [15:0]                   tcnt_q;
    logic [NUM_SLOTS-1:0][13:0]    shadow_q;
    logic [NUM_SLOTS-1:0][13:0]    shadow_d;
    logic [NUM_SLOTS-1:0][13:0]    active_q;
    logic                          busy_q;
    logic                          pkt_err_q;
    logic                          commit_q;
    logic                          clear_all;
    logic                          slot_ok;

`ifdef ENTITY_CLEAR_ALL_EN
    assign clear_all = (state_q == IDLE) && data_valid && (data_in == 8'hFF);
`else
    assign clear_all = 1'b0;
`endif

    assign slot_ok = ({1'b0, slot_q} < SLOT_LIMIT);

    // Next shadow contents; also feeds the active bank so a same-edge write is committed.
    always_comb begin
        shadow_d = shadow_q;
        if (clear_all) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                shadow_d[k] = UNUSED_WORD;
            end
        end else if ((state_q == GOT_B1) && data_valid) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (slot_q == 4'(k)) begin
                    shadow_d[k] = {id_q, orient_q, data_in};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            id_q      <= '0;
            orient_q  <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            pkt_err_q <= 1'b0;
            commit_q  <= 1'b0;
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                shadow_q[k] <= UNUSED_WORD;
                active_q[k] <= UNUSED_WORD;
            end
        end else begin
            pkt_err_q <= 1'b0;
            commit_q  <= frame_start;
            shadow_q  <= shadow_d;
            if (frame_start) begin
                active_q <= shadow_d;
            end

            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (data_valid && !clear_all) begin
                        slot_q  <= data_in[7:4];
                        id_q    <= data_in[3:0];
                        state_q <= GOT_B0;
                        busy_q  <= 1'b1;
                    end
                end
                GOT_B0, GOT_B1: begin
                    if (data_valid) begin
                        tcnt_q <= '0;
                        if (state_q == GOT_B0) begin
                            orient_q <= data_in[7:6];
                            state_q  <= GOT_B1;
                        end else begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            pkt_err_q <= !slot_ok;
                        end
                    end else if (tcnt_q == TMO_LAST) begin
                        // The TIMEOUT-th consecutive idle cycle aborts; a byte in that cycle wins instead.
                        tcnt_q    <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        pkt_err_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    assign entities = active_q;
    assign busy     = busy_q;
    assign pkt_err  = pkt_err_q;
    assign commit   = commit_q;

endmodule
